// File: rtl/ctrl_pkg.sv
// Shared control definitions: FSM state encodings, instruction field
// constants, ALU function codes and the decoded instruction class.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  // Instruction class latched in DECODE; CLS_NONE doubles as "unsupported".
  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_RTYPE = 3'd1,
    CLS_LW    = 3'd2,
    CLS_SW    = 3'd3,
    CLS_ADDI  = 3'd4,
    CLS_ANDI  = 3'd5,
    CLS_ORI   = 3'd6
  } class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Registered datapath controls, one bundle so they reset and load together.
  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  // Map raw instruction fields to a class; anything unsupported is CLS_NONE.
  function automatic class_t decode_class(input logic [5:0] opcode,
                                          input logic [5:0] funct);
    class_t cls;
    cls = CLS_NONE;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: cls = CLS_RTYPE;
          default:                               cls = CLS_NONE;
        endcase
      end
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_ADDI: cls = CLS_ADDI;
      OP_ANDI: cls = CLS_ANDI;
      OP_ORI:  cls = CLS_ORI;
      default: cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction-in / controls-out bundle between the sequencer and its user.
interface multicycle_control_if;

  logic        run;
  logic [5:0]  opcode;
  logic [5:0]  funct;

  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        ALUSrc;
  logic        RegDst;
  logic [3:0]  ALU_OP;
  logic [2:0]  state;
  logic        instr_done;
  logic        illegal;
  logic [15:0] instr_count;

  // Driver side: supplies run and the instruction fields, observes controls.
  modport master (
    output run, opcode, funct,
    input  IRWrite, PCWrite, RegWrite, MemRead, MemWrite, MemtoReg,
           ALUSrc, RegDst, ALU_OP, state, instr_done, illegal, instr_count
  );

  // Controller side.
  modport slave (
    input  run, opcode, funct,
    output IRWrite, PCWrite, RegWrite, MemRead, MemWrite, MemtoReg,
           ALUSrc, RegDst, ALU_OP, state, instr_done, illegal, instr_count
  );

endinterface

// File: rtl/alu_op_decoder.sv
// Combinational map from the latched instruction class (and funct for
// R-type) to the 4-bit ALU function code.
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  class_t     cls,
  input  logic [5:0] funct,
  output logic [3:0] alu_op
);

  // Memory ops and addi use add; logical immediates pick their own op.
  always_comb begin
    alu_op = ALU_AND;
    case (cls)
      CLS_LW, CLS_SW, CLS_ADDI: alu_op = ALU_ADD;
      CLS_ANDI:                 alu_op = ALU_AND;
      CLS_ORI:                  alu_op = ALU_OR;
      CLS_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_AND;
        endcase
      end
      default: alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB plus a
// sticky TRAP for unsupported instructions. All outputs are registered and
// derived from the next state and next latched class, so they behave as
// Moore outputs of the state register with no path from run/opcode/funct.
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  multicycle_control_if.slave bus
);

  state_t      state_q, state_d;
  class_t      class_q, class_d;
  logic [5:0]  funct_q, funct_d;
  logic        illegal_q, illegal_d;
  logic [15:0] count_q, count_d;
  ctrl_t       ctrl_q, ctrl_d;

  class_t      dec_class;
  logic        final_state;
  logic        in_datapath;
  logic [3:0]  alu_op_next;

  // ALU function for the class/funct that will be held next cycle.
  alu_op_decoder u_alu_op_decoder (
    .cls    (class_d),
    .funct  (funct_d),
    .alu_op (alu_op_next)
  );

  // Next-state, class latch, counter and registered-output computation.
  always_comb begin
    // NOTE: every _d signal is given its hold value first so no branch can leave it unassigned and infer a latch.
    state_d   = state_q;
    class_d   = class_q;
    funct_d   = funct_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    ctrl_d    = '0;

    dec_class   = decode_class(bus.opcode, bus.funct);
    final_state = (state_q == ST_WB) ||
                  ((state_q == ST_MEM) && (class_q == CLS_SW));

    case (state_q)
      ST_IDLE:   if (bus.run) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_class == CLS_NONE) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
          class_d = dec_class;
          funct_d = bus.funct;
        end
      end
      ST_EXEC: begin
        if ((class_q == CLS_LW) || (class_q == CLS_SW)) state_d = ST_MEM;
        else                                            state_d = ST_WB;
      end
      ST_MEM:  if (class_q == CLS_LW) state_d = ST_WB;
      ST_WB:   state_d = ST_WB;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase

    // Retire: bump the counter and either fetch again or park in IDLE.
    if (final_state) begin
      count_d = count_q + 16'd1;
      state_d = bus.run ? ST_FETCH : ST_IDLE;
    end

    // Controls for the cycle spent in state_d, using the class held then.
    in_datapath = (state_d == ST_EXEC) || (state_d == ST_MEM) || (state_d == ST_WB);
    ctrl_d.ir_write  = (state_d == ST_FETCH);
    ctrl_d.pc_write  = (state_d == ST_FETCH);
    ctrl_d.reg_write = (state_d == ST_WB);
    ctrl_d.mem_read  = (state_d == ST_MEM) && (class_d == CLS_LW);
    ctrl_d.mem_write = (state_d == ST_MEM) && (class_d == CLS_SW);
    if (in_datapath) begin
      ctrl_d.alu_src    = (class_d != CLS_RTYPE);
      ctrl_d.reg_dst    = (class_d == CLS_RTYPE);
      ctrl_d.mem_to_reg = (class_d == CLS_LW);
      ctrl_d.alu_op     = alu_op_next;
    end
    ctrl_d.instr_done = (state_d == ST_WB) ||
                        ((state_d == ST_MEM) && (class_d == CLS_SW));
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q   <= ST_IDLE;
      class_q   <= CLS_NONE;
      funct_q   <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      funct_q   <= funct_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign bus.IRWrite     = ctrl_q.ir_write;
  assign bus.PCWrite     = ctrl_q.pc_write;
  assign bus.RegWrite    = ctrl_q.reg_write;
  assign bus.MemRead     = ctrl_q.mem_read;
  assign bus.MemWrite    = ctrl_q.mem_write;
  assign bus.MemtoReg    = ctrl_q.mem_to_reg;
  assign bus.ALUSrc      = ctrl_q.alu_src;
  assign bus.RegDst      = ctrl_q.reg_dst;
  assign bus.ALU_OP      = ctrl_q.alu_op;
  assign bus.instr_done  = ctrl_q.instr_done;
  assign bus.state       = state_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: lw/sw/R-type/immediate sequences,
// run dropping mid-instruction, trap entry and exit, reset mid-instruction
// and instruction-counter wrap.
module tb_multicycle_control;
  import ctrl_pkg::*;

  // Control vector order: {IRWrite,PCWrite,RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,RegDst}
  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_FETCH = 8'b1100_0000;
  localparam logic [7:0] C_RW    = 8'b0010_0000;
  localparam logic [7:0] C_MR    = 8'b0001_0000;
  localparam logic [7:0] C_MW    = 8'b0000_1000;
  localparam logic [7:0] C_M2R   = 8'b0000_0100;
  localparam logic [7:0] C_ASRC  = 8'b0000_0010;
  localparam logic [7:0] C_RDST  = 8'b0000_0001;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout simulation exceeded its time bound");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] ctl_obs();
    return {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemRead,
            bus.MemWrite, bus.MemtoReg, bus.ALUSrc, bus.RegDst};
  endfunction

  task automatic cyc(input string tag, input logic [2:0] st, input logic [7:0] ctl,
                     input logic [3:0] aop, input logic done);
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".ctl"},   32'(ctl_obs()), 32'(ctl));
    check({tag, ".aluop"}, 32'(bus.ALU_OP), 32'(aop));
    check({tag, ".done"},  32'(bus.instr_done), 32'(done));
  endtask

  // Four-cycle ALU instruction, entered while in FETCH; loads the next
  // instruction fields and run level after the WB check.
  task automatic alu_instr(input string tag, input logic [7:0] ctl, input logic [3:0] aop,
                           input logic [5:0] nop, input logic [5:0] nfn, input logic nrun);
    cyc({tag, ".fetch"}, 3'd1, C_FETCH, 4'd0, 1'b0);
    tick();
    cyc({tag, ".decode"}, 3'd2, C_NONE, 4'd0, 1'b0);
    tick();
    cyc({tag, ".exec"}, 3'd3, ctl, aop, 1'b0);
    tick();
    cyc({tag, ".wb"}, 3'd5, ctl | C_RW, aop, 1'b1);
    bus.opcode = nop;
    bus.funct  = nfn;
    bus.run    = nrun;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst        = 1'b0;
    bus.run    = 1'b0;
    bus.opcode = OP_LW;
    bus.funct  = 6'd0;

    // Reset state.
    tick();
    tick();
    cyc("reset", 3'd0, C_NONE, 4'd0, 1'b0);
    check("reset.count", 32'(bus.instr_count), 32'd0);
    check("reset.illegal", 32'(bus.illegal), 32'd0);

    // lw from reset: IDLE, FETCH, DECODE, EXEC, MEM, WB.
    rst     = 1'b1;
    bus.run = 1'b1;
    tick();
    cyc("lw.fetch", 3'd1, C_FETCH, 4'd0, 1'b0);
    tick();
    cyc("lw.decode", 3'd2, C_NONE, 4'd0, 1'b0);
    tick();
    cyc("lw.exec", 3'd3, C_ASRC | C_M2R, ALU_ADD, 1'b0);
    tick();
    cyc("lw.mem", 3'd4, C_MR | C_ASRC | C_M2R, ALU_ADD, 1'b0);
    tick();
    cyc("lw.wb", 3'd5, C_RW | C_ASRC | C_M2R, ALU_ADD, 1'b1);
    check("lw.wb.count", 32'(bus.instr_count), 32'd0);
    bus.run = 1'b0;
    tick();
    cyc("lw.idle", 3'd0, C_NONE, 4'd0, 1'b0);
    check("lw.count", 32'(bus.instr_count), 32'd1);

    // run dropped during EXEC of lw: instruction completes, then IDLE.
    bus.run = 1'b1;
    tick();
    tick();
    tick();
    cyc("drop.exec", 3'd3, C_ASRC | C_M2R, ALU_ADD, 1'b0);
    bus.run = 1'b0;
    tick();
    cyc("drop.mem", 3'd4, C_MR | C_ASRC | C_M2R, ALU_ADD, 1'b0);
    tick();
    cyc("drop.wb", 3'd5, C_RW | C_ASRC | C_M2R, ALU_ADD, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      cyc("drop.idle", 3'd0, C_NONE, 4'd0, 1'b0);
    end
    check("drop.count", 32'(bus.instr_count), 32'd2);

    // sw then add back to back with run held high.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst2.count", 32'(bus.instr_count), 32'd0);
    bus.opcode = OP_SW;
    bus.run    = 1'b1;
    tick();
    cyc("sw.fetch", 3'd1, C_FETCH, 4'd0, 1'b0);
    tick();
    cyc("sw.decode", 3'd2, C_NONE, 4'd0, 1'b0);
    tick();
    cyc("sw.exec", 3'd3, C_ASRC, ALU_ADD, 1'b0);
    tick();
    cyc("sw.mem", 3'd4, C_MW | C_ASRC, ALU_ADD, 1'b1);
    bus.opcode = OP_RTYPE;
    bus.funct  = FN_ADD;
    tick();
    cyc("add.fetch", 3'd1, C_FETCH, 4'd0, 1'b0);
    check("sw.count", 32'(bus.instr_count), 32'd1);
    tick();
    cyc("add.decode", 3'd2, C_NONE, 4'd0, 1'b0);
    tick();
    cyc("add.exec", 3'd3, C_RDST, ALU_ADD, 1'b0);
    tick();
    cyc("add.wb", 3'd5, C_RW | C_RDST, ALU_ADD, 1'b1);
    bus.opcode = OP_ANDI;
    bus.funct  = 6'd0;
    tick();
    check("swadd.count8", 32'(bus.instr_count), 32'd2);

    // andi, ori, sub, slt, four cycles each.
    alu_instr("andi", C_ASRC, ALU_AND, OP_ORI,   6'd0,   1'b1);
    alu_instr("ori",  C_ASRC, ALU_OR,  OP_RTYPE, FN_SUB, 1'b1);
    alu_instr("sub",  C_RDST, ALU_SUB, OP_RTYPE, FN_SLT, 1'b1);
    alu_instr("slt",  C_RDST, ALU_SLT, OP_LW,    6'd0,   1'b0);
    cyc("seq.idle", 3'd0, C_NONE, 4'd0, 1'b0);
    check("seq.count", 32'(bus.instr_count), 32'd6);

    // Unsupported opcode traps; run is ignored until reset.
    bus.opcode = 6'b111111;
    bus.run    = 1'b1;
    tick();
    tick();
    cyc("trapop.decode", 3'd2, C_NONE, 4'd0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      tick();
      cyc("trapop.hold", 3'd6, C_NONE, 4'd0, 1'b0);
      check("trapop.illegal", 32'(bus.illegal), 32'd1);
    end
    check("trapop.count", 32'(bus.instr_count), 32'd6);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    cyc("trapop.reset", 3'd0, C_NONE, 4'd0, 1'b0);
    check("trapop.reset.illegal", 32'(bus.illegal), 32'd0);
    check("trapop.reset.count", 32'(bus.instr_count), 32'd0);

    // R-type with unsupported funct traps as well.
    bus.opcode = OP_RTYPE;
    bus.funct  = 6'b000000;
    tick();
    tick();
    for (int i = 0; i < 11; i++) begin
      tick();
      cyc("trapfn.hold", 3'd6, C_NONE, 4'd0, 1'b0);
      check("trapfn.illegal", 32'(bus.illegal), 32'd1);
    end
    rst = 1'b0;
    tick();
    rst        = 1'b1;
    bus.run    = 1'b0;
    bus.opcode = OP_LW;
    cyc("trapfn.reset", 3'd0, C_NONE, 4'd0, 1'b0);
    check("trapfn.reset.illegal", 32'(bus.illegal), 32'd0);

    // Reset in the middle of an lw (in MEM).
    bus.run = 1'b1;
    tick();
    tick();
    tick();
    tick();
    cyc("midrst.mem", 3'd4, C_MR | C_ASRC | C_M2R, ALU_ADD, 1'b0);
    rst     = 1'b0;
    bus.run = 1'b0;
    tick();
    rst = 1'b1;
    cyc("midrst.reset", 3'd0, C_NONE, 4'd0, 1'b0);
    check("midrst.count", 32'(bus.instr_count), 32'd0);
    tick();
    cyc("midrst.idle", 3'd0, C_NONE, 4'd0, 1'b0);

    // Counter wrap: preload 0xFFFF, retire one addi.
    force dut.count_q = 16'hFFFF;
    tick();
    release dut.count_q;
    tick();
    check("wrap.preload", 32'(bus.instr_count), 32'h0000FFFF);
    bus.opcode = OP_ADDI;
    bus.run    = 1'b1;
    tick();
    tick();
    tick();
    cyc("wrap.exec", 3'd3, C_ASRC, ALU_ADD, 1'b0);
    tick();
    cyc("wrap.wb", 3'd5, C_RW | C_ASRC, ALU_ADD, 1'b1);
    bus.run = 1'b0;
    tick();
    check("wrap.count", 32'(bus.instr_count), 32'd0);
    check("wrap.idle", 32'(bus.state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
